// File: rtl/pc_sequencer_if.sv
// Fetch handshake, redirect inputs and architectural state outputs of pc_sequencer.
// master = the sequencer itself; slave = instruction memory / datapath side.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        exc_req;
  logic        eret;
  logic [31:0] PC;
  logic [31:0] EPC;
  logic        exl;
  logic [1:0]  cause;
  logic [31:0] instret;
  logic        in_exec;

  modport master (
    output imem_req, imem_addr, PC, EPC, exl, cause, instret, in_exec,
    input  imem_ack, stall, br_taken, br_target, jmp, jmp_target, exc_req, eret
  );

  modport slave (
    input  imem_req, imem_addr, PC, EPC, exl, cause, instret, in_exec,
    output imem_ack, stall, br_taken, br_target, jmp, jmp_target, exc_req, eret
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/next-PC controller: owns PC, EPC, exception level, cause and retired count,
// stepping IDLE -> FETCH -> EXEC and choosing the next PC on every EXEC exit.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180
) (
  input  logic           clk,
  input  logic           Reset,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_EXT  = 2'd1;
  localparam logic [1:0] CAUSE_MIS  = 2'd2;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_epc, w_epc_next;
  logic [31:0] r_instret, w_instret_next;
  logic        r_exl, w_exl_next;
  logic [1:0]  r_cause, w_cause_next;

  logic        w_redirect;
  logic        w_misaligned;
  logic [31:0] w_target;
  logic [31:0] w_pc_seq;
  logic [31:0] w_instret_inc;

  // jmp outranks br_taken when both are asserted
  assign w_redirect    = bus.jmp | bus.br_taken;
  assign w_target      = bus.jmp ? bus.jmp_target : bus.br_target;
  assign w_misaligned  = w_redirect & (w_target[1:0] != 2'b00);
  assign w_pc_seq      = r_pc + 32'd4;
  assign w_instret_inc = r_instret + 32'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_epc_next     = r_epc;
    w_exl_next     = r_exl;
    w_cause_next   = r_cause;
    w_instret_next = r_instret;

    unique case (r_state)
      S_IDLE: w_state_next = S_FETCH;

      S_FETCH: begin
        if (bus.imem_ack) w_state_next = S_EXEC;
      end

      S_EXEC: begin
        if (bus.exc_req && !r_exl) begin
          w_state_next = S_FETCH;
          w_epc_next   = r_pc;
          w_pc_next    = EXC_VECTOR;
          w_exl_next   = 1'b1;
          w_cause_next = CAUSE_EXT;
        end else if (bus.eret) begin
          w_state_next   = S_FETCH;
          w_pc_next      = r_epc;
          w_exl_next     = 1'b0;
          w_cause_next   = CAUSE_NONE;
          w_instret_next = w_instret_inc;
        end else if (w_misaligned && !r_exl) begin
          w_state_next = S_FETCH;
          w_epc_next   = r_pc;
          w_pc_next    = EXC_VECTOR;
          w_exl_next   = 1'b1;
          w_cause_next = CAUSE_MIS;
        end else if (w_misaligned) begin
          // Inside the handler a bad target is dropped and execution falls through.
          w_state_next   = S_FETCH;
          w_pc_next      = w_pc_seq;
          w_instret_next = w_instret_inc;
        end else if (w_redirect) begin
          w_state_next   = S_FETCH;
          w_pc_next      = w_target;
          w_instret_next = w_instret_inc;
        end else if (!bus.stall) begin
          w_state_next   = S_FETCH;
          w_pc_next      = w_pc_seq;
          w_instret_next = w_instret_inc;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_pc      <= RESET_VECTOR;
      r_epc     <= 32'd0;
      r_exl     <= 1'b0;
      r_cause   <= CAUSE_NONE;
      r_instret <= 32'd0;
    end else begin
      r_pc      <= w_pc_next;
      r_epc     <= w_epc_next;
      r_exl     <= w_exl_next;
      r_cause   <= w_cause_next;
      r_instret <= w_instret_next;
    end
  end

  assign bus.imem_req  = (r_state == S_FETCH);
  assign bus.in_exec   = (r_state == S_EXEC);
  assign bus.imem_addr = r_pc;
  assign bus.PC        = r_pc;
  assign bus.EPC       = r_epc;
  assign bus.exl       = r_exl;
  assign bus.cause     = r_cause;
  assign bus.instret   = r_instret;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/next-PC controller for the single-cycle CPU datapath. Owns the program counter register, drives the instruction-memory fetch handshake, and selects the next PC each instruction from sequential, branch, jump, exception and exception-return sources. Also holds EPC, the exception-level flag and a retired-instruction counter.

## Interface
- RESET_VECTOR, 32'h0000_3000, PC value loaded on reset
- EXC_VECTOR, 32'h0000_4180, PC value loaded on exception entry
- clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request, high only in FETCH
- imem_addr  out  32  fetch address, equals PC
- imem_ack  in  1  fetch complete; instruction valid this cycle
- stall  in  1  hold current instruction in EXEC
- br_taken  in  1  conditional branch taken
- br_target  in  32  branch target
- jmp  in  1  jump / jump-register
- jmp_target  in  32  jump target
- exc_req  in  1  external exception request
- eret  in  1  exception return
- PC  out  32  current PC
- EPC  out  32  saved exception PC
- exl  out  1  exception level (in handler)
- cause  out  2  0 none, 1 external, 2 misaligned target
- instret  out  32  retired-instruction count
- in_exec  out  1  high in EXEC; datapath executes instruction

## Operation
- Three states: IDLE, FETCH, EXEC.
- IDLE: entered only by Reset; imem_req=0; unconditional move to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=PC; hold until imem_ack=1, then EXEC. PC unchanged.
- EXEC: in_exec=1; redirect inputs sampled once, fixed priority:
  - exc_req & ~exl: EPC<=PC, PC<=EXC_VECTOR, exl<=1, cause<=1, -> FETCH.
  - eret: PC<=EPC, exl<=0, cause<=0, -> FETCH.
  - jmp: target=jmp_target; br_taken: target=br_target.
  - selected target with [1:0]!=0: misaligned exception: EPC<=PC, PC<=EXC_VECTOR, exl<=1, cause<=2, -> FETCH. If exl already 1: target ignored, PC<=PC+4.
  - aligned target: PC<=target, -> FETCH.
  - stall (no higher source): stay in EXEC, PC unchanged.
  - otherwise: PC<=PC+4, -> FETCH.
- exc_req while exl=1: ignored; lower-priority sources evaluated normally.
- eret while exl=0: still PC<=EPC (software error, not detected).
- stall has lower priority than exc_req/eret/jmp/br_taken.
- instret increments by 1 on every EXEC exit that is not exception entry (external or misaligned); not on stall cycles.

## Timing
- Reset (synchronous, dominates all inputs): PC=RESET_VECTOR, EPC=0, exl=0, cause=0, instret=0, state IDLE, imem_req=0, in_exec=0 on the cycle after the Reset edge.
- Reset mid-FETCH or mid-EXEC: aborts; imem_req low next cycle; pending ack ignored.
- Minimum 2 cycles per instruction (FETCH with immediate ack, then EXEC); +1 per wait cycle, +1 per stall cycle.
- imem_ack outside FETCH ignored. Redirect inputs outside EXEC ignored.
- All outputs registered or decoded from state; no combinational input-to-output paths except none (imem_addr=PC register).
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). instret wraps 32'hFFFF_FFFF -> 0.
- exl, cause, EPC change only on EXEC exit edges or Reset.

## Test plan
- Reset then ack every FETCH, no redirects: imem_addr sequence 0x3000, 0x3004, 0x3008; instret=3 after third EXEC; first imem_req one cycle after IDLE.
- FETCH with 3 wait cycles at 0x3000: imem_req held 4 cycles, PC stable; EXEC with stall=1 for 2 cycles: PC stays 0x3000, instret unchanged, then 0x3004.
- EXEC at 0x3010 with jmp=1 jmp_target=0x3100 and br_taken=1 br_target=0x3200: next fetch 0x3100; with jmp_target=0x3102: PC=0x4180, EPC=0x3010, cause=2, exl=1, instret unchanged.
- EXEC at 0x3020 with exc_req=1 and jmp=1: PC=0x4180, EPC=0x3020, cause=1; second exc_req in handler ignored (PC+4); eret: PC=0x3020, exl=0.
- PC forced to 0xFFFF_FFFC, sequential EXEC: next PC 0x0000_0000; instret at 0xFFFF_FFFF wraps to 0.
- Reset asserted during FETCH with imem_ack=1 same cycle: next cycle state IDLE, PC=0x3000, instret=0, imem_req=0.
